lbus_host_bridge: RTL and testbench

//  Byte-stream to local-bus master; sits directly upstream of the cipher local-bus slave.

---
 rtl/lbus_pkg.sv | 39 +++
 rtl/lbus_host_bridge_if.sv | 26 ++
 rtl/lbus_host_bridge.sv | 112 +++++++++++
 tb/tb_lbus_host_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lbus_pkg.sv
// Shared definitions for the host-to-local-bus bridge.
//  - host command bytes
//  - FSM state encodings (plain constants for legacy tools)
//  - local-bus address map of the downstream cipher slave
package lbus_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  localparam logic [15:0] ADDR_CTRL   = 16'h0002;
  localparam logic [15:0] ADDR_ENCDEC = 16'h000C;
  localparam logic [15:0] ADDR_KEY    = 16'h0100;
  localparam logic [15:0] ADDR_DIN    = 16'h0140;
  localparam logic [15:0] ADDR_DOUT   = 16'h0180;
  localparam logic [15:0] ADDR_ID     = 16'hFFFC;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_WA_H      = 4'd1;
  localparam state_t S_WA_L      = 4'd2;
  localparam state_t S_WD_H      = 4'd3;
  localparam state_t S_WD_L      = 4'd4;
  localparam state_t S_WR_ASSERT = 4'd5;
  localparam state_t S_WR_GAP    = 4'd6;
  localparam state_t S_RA_H      = 4'd7;
  localparam state_t S_RA_L      = 4'd8;
  localparam state_t S_RD_WAIT   = 4'd9;
  localparam state_t S_RD_FREEZE = 4'd10;
  localparam state_t S_TX_H      = 4'd11;
  localparam state_t S_TX_L      = 4'd12;

  // States in which a host byte may be taken.
  function automatic logic rx_state(input state_t s);
    return (s == S_IDLE) || (s == S_WA_H) || (s == S_WA_L) || (s == S_WD_H) ||
           (s == S_WD_L) || (s == S_RA_H) || (s == S_RA_L);
  endfunction

endpackage

// File: rtl/lbus_host_bridge_if.sv
// Host byte stream + local-bus signal bundle.
//  master : bridge side (consumes rx bytes, produces tx bytes, drives lbus)
//  slave  : host/slave side (byte source/sink and local-bus slave)
interface lbus_host_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] lbus_a;
  logic [15:0] lbus_di;
  logic        lbus_wr;
  logic        lbus_rd;
  logic [15:0] lbus_do;

  modport master (
    input  rx_data, rx_valid, tx_ready, lbus_do,
    output rx_ready, tx_data, tx_valid, lbus_a, lbus_di, lbus_wr, lbus_rd
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, lbus_do,
    input  rx_ready, tx_data, tx_valid, lbus_a, lbus_di, lbus_wr, lbus_rd
  );
endinterface

// File: rtl/lbus_host_bridge.sv
// Byte-stream to local-bus master.
// Decodes big-endian host packets into lbus cycles:
//   write: 01 AH AL DH DL      read: 00 AH AL -> reply DH DL
// Ports:
//   clk, rstn : clock, async active-low reset
//   bus       : host rx/tx byte handshakes + local-bus (master modport)
//   busy      : FSM not in IDLE
// All bus outputs are registered so reset clears them asynchronously.
module lbus_host_bridge
  import lbus_pkg::*;
#(
  parameter int WR_HOLD = 4,  // cycles lbus_wr high
  parameter int WR_GAP  = 2,  // cycles lbus_wr low before next command
  parameter int RD_WAIT = 3   // cycles lbus_a settles into slave's registered dout
) (
  input  logic               clk,
  input  logic               rstn,
  lbus_host_bridge_if.master bus,
  output logic               busy
);

  localparam int CNT_W = 8;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        hold;
  logic               acc;
  logic               cnt_zero;

  assign acc      = bus.rx_valid & bus.rx_ready;
  assign cnt_zero = (cnt == '0);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (acc) begin
        if (bus.rx_data == CMD_READ)       state_nxt = S_RA_H;
        else if (bus.rx_data == CMD_WRITE) state_nxt = S_WA_H;
      end
      S_WA_H:      if (acc) state_nxt = S_WA_L;
      S_WA_L:      if (acc) state_nxt = S_WD_H;
      S_WD_H:      if (acc) state_nxt = S_WD_L;
      S_WD_L:      if (acc) state_nxt = S_WR_ASSERT;
      S_WR_ASSERT: if (cnt_zero) state_nxt = S_WR_GAP;
      S_WR_GAP:    if (cnt_zero) state_nxt = S_IDLE;
      S_RA_H:      if (acc) state_nxt = S_RA_L;
      S_RA_L:      if (acc) state_nxt = S_RD_WAIT;
      S_RD_WAIT:   if (cnt_zero) state_nxt = S_RD_FREEZE;
      S_RD_FREEZE: state_nxt = S_TX_H;
      S_TX_H:      if (bus.tx_ready) state_nxt = S_TX_L;
      S_TX_L:      if (bus.tx_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hold         <= '0;
      bus.rx_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.lbus_a   <= '0;
      bus.lbus_di  <= '0;
      bus.lbus_wr  <= 1'b0;
      bus.lbus_rd  <= 1'b0;
    end else begin
      state        <= state_nxt;
      // rx_ready follows the state we are about to enter, so it drops on
      // the same edge that completes a packet.
      bus.rx_ready <= rx_state(state_nxt);
      case (state)
        S_WA_H, S_RA_H: if (acc) bus.lbus_a[15:8] <= bus.rx_data;
        S_WA_L:         if (acc) bus.lbus_a[7:0]  <= bus.rx_data;
        S_WD_H:         if (acc) bus.lbus_di[15:8] <= bus.rx_data;
        S_WD_L: if (acc) begin
          bus.lbus_di[7:0] <= bus.rx_data;
          bus.lbus_wr      <= 1'b1;
          cnt              <= CNT_W'(WR_HOLD - 1);
        end
        S_WR_ASSERT: if (cnt_zero) begin
          bus.lbus_wr <= 1'b0;
          cnt         <= CNT_W'(WR_GAP - 1);
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_WR_GAP: if (!cnt_zero) cnt <= cnt - 1'b1;
        S_RA_L: if (acc) begin
          bus.lbus_a[7:0] <= bus.rx_data;
          cnt             <= CNT_W'(RD_WAIT - 1);
        end
        S_RD_WAIT: if (cnt_zero) bus.lbus_rd <= 1'b1;
                   else          cnt <= cnt - 1'b1;
        // Slave dout is frozen this cycle; capture both bytes at once.
        S_RD_FREEZE: begin
          hold         <= bus.lbus_do;
          bus.tx_data  <= bus.lbus_do[15:8];
          bus.tx_valid <= 1'b1;
        end
        S_TX_H: if (bus.tx_ready) bus.tx_data <= hold[7:0];
        S_TX_L: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          bus.lbus_rd  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_host_bridge.sv
// Directed bench for lbus_host_bridge: host byte driver, tx sink, and a
// registered-dout local-bus slave model with a fixed register map.
module tb_lbus_host_bridge;
  import lbus_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   wr_rises = 0;
  int   tx_cnt = 0;
  logic wr_q = 1'b0;
  logic [7:0] b0, b1;

  lbus_host_bridge_if bus();

  lbus_host_bridge dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] slave_reg(input logic [15:0] a);
    case (a)
      ADDR_ID:   return 16'h4702;
      ADDR_CTRL: return 16'h0005;
      ADDR_DOUT: return 16'hBEEF;
      default:   return 16'h0000;
    endcase
  endfunction

  // Slave: dout tracks address while not frozen, one register stage.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bus.lbus_do <= '0;
    else if (!bus.lbus_rd) bus.lbus_do <= slave_reg(bus.lbus_a);
  end

  always @(posedge clk) begin
    wr_q <= bus.lbus_wr;
    if (bus.lbus_wr && !wr_q) wr_rises <= wr_rises + 1;
    if (bus.tx_valid && bus.tx_ready) tx_cnt <= tx_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) chk("rx_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    last_acc = cyc;
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) chk("tx_timeout", 32'(bus.tx_valid), 32'd1);
    b = bus.tx_data;
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] hi, output logic [7:0] lo);
    send_byte(CMD_READ);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    recv_byte(hi);
    recv_byte(lo);
  endtask

  initial begin
    int acc_wd;
    int rises0;
    int tx0;
    logic ok_v, ok_d, ok_r;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    // reset state
    #2;
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_lbus_a", 32'(bus.lbus_a), 32'd0);
    chk("rst_lbus_di", 32'(bus.lbus_di), 32'd0);
    chk("rst_wr_rd", {30'd0, bus.lbus_wr, bus.lbus_rd}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: write 0x1234 to KEY; wr high 4, low 2, then ready
    send_byte(CMD_WRITE); send_byte(8'h01); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    chk("t1_lbus_a", 32'(bus.lbus_a), 32'h0100);
    chk("t1_lbus_di", 32'(bus.lbus_di), 32'h1234);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("t1_wr_high", {30'd0, bus.lbus_wr, bus.rx_ready}, 32'b10);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t1_wr_gap", {30'd0, bus.lbus_wr, bus.rx_ready}, 32'b00);
    end
    @(negedge clk);
    chk("t1_ready_after", {30'd0, bus.lbus_wr, bus.rx_ready}, 32'b01);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: read ID, check rd timing, tx latency and bytes
    send_byte(CMD_READ); send_byte(8'hFF); send_byte(8'hFC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_rd_wait", {30'd0, bus.lbus_rd, bus.tx_valid}, 32'b00);
    end
    @(negedge clk);
    chk("t2_freeze", {30'd0, bus.lbus_rd, bus.tx_valid}, 32'b10);
    recv_byte(b0);
    recv_byte(b1);
    chk("t2_bytes", {16'd0, b0, b1}, 32'h4702);
    @(negedge clk);
    chk("t2_rd_released", {30'd0, bus.lbus_rd, bus.tx_valid}, 32'b00);
    chk("t2_ready", 32'(bus.rx_ready), 32'd1);

    // 3: junk byte dropped, then read CTRL
    rises0 = wr_rises;
    send_byte(8'h55);
    @(negedge clk);
    chk("t3_drop_idle", {29'd0, busy, bus.lbus_wr, bus.lbus_rd}, 32'd0);
    chk("t3_drop_addr", 32'(bus.lbus_a), 32'hFFFC);
    do_read(ADDR_CTRL, b0, b1);
    chk("t3_bytes", {16'd0, b0, b1}, 32'h0005);
    chk("t3_no_wr", wr_rises - rises0, 32'd0);

    // 4: tx backpressure for 10 cycles, host keeps offering a byte
    tx0 = tx_cnt;
    send_byte(CMD_READ); send_byte(8'hFF); send_byte(8'hFC);
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    for (int n = 0; n < 50 && !bus.tx_valid; n++) @(negedge clk);
    ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.tx_valid) ok_v = 1'b0;
      if (bus.tx_data !== 8'h47) ok_d = 1'b0;
      if (bus.rx_ready) ok_r = 1'b0;
    end
    chk("t4_valid_held", 32'(ok_v), 32'd1);
    chk("t4_data_stable", 32'(ok_d), 32'd1);
    chk("t4_rx_stalled", 32'(ok_r), 32'd0 + 32'd1);
    bus.rx_valid = 1'b0;
    recv_byte(b0);
    recv_byte(b1);
    chk("t4_bytes", {16'd0, b0, b1}, 32'h4702);
    repeat (3) @(negedge clk);
    chk("t4_tx_count", tx_cnt - tx0, 32'd2);
    chk("t4_no_extra", 32'(bus.tx_valid), 32'd0);

    // 5: write CTRL then read DOUT back-to-back
    rises0 = wr_rises;
    send_byte(CMD_WRITE); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    acc_wd = last_acc;
    send_byte(CMD_READ);
    chk("t5_stall", last_acc - acc_wd, 32'd7);
    send_byte(8'h01); send_byte(8'h80);
    recv_byte(b0);
    recv_byte(b1);
    chk("t5_bytes", {16'd0, b0, b1}, 32'hBEEF);
    chk("t5_one_rise", wr_rises - rises0, 32'd1);

    // 6: reset mid WR_ASSERT, then recover
    send_byte(CMD_WRITE); send_byte(8'h01); send_byte(8'h40); send_byte(8'hAA); send_byte(8'h55);
    @(negedge clk);
    chk("t6_wr_c1", 32'(bus.lbus_wr), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_wr_async", 32'(bus.lbus_wr), 32'd0);
    chk("t6_regs_async", {bus.lbus_a, bus.lbus_di}, 32'd0);
    chk("t6_busy_async", {30'd0, busy, bus.rx_ready}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    do_read(ADDR_ID, b0, b1);
    chk("t6_recover", {16'd0, b0, b1}, 32'h4702);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
